cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002: reset  input  1  asynchronous, active-high reset.
REQ-003: start  input  1  level; leaves IDLE when sampled high.
REQ-004: imem_req  output  1  instruction fetch request.
REQ-005: imem_addr  output  8  fetch address, always equal to pc.
REQ-006: imem_ready  input  1  fetch data valid this cycle.
REQ-007: imem_rdata  input  20  fetched instruction word.
REQ-008: instruction  output  20  instruction register (IR), drives the decoder.
REQ-009: jump_address  input  8  decoder jump target.
REQ-010: branch_offset  input  8  decoder signed branch offset.
REQ-011: alu_zero  input  1  ALU zero flag, valid during EXEC.
REQ-012: alu_en  output  1  ALU result capture strobe.
REQ-013: reg_we  output  1  register-file write enable.
REQ-014: dmem_req, dmem_we  output  1 each  data memory request and write qualifier.
REQ-015: dmem_ready  input  1  data access complete this cycle.
REQ-016: pc  output  8  program counter.
REQ-017: state  output  3  current FSM state, exposed for debug.
REQ-018: halted  output  1  high while in HALT.

Function
REQ-019: FSM states SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; all outputs are registered or decoded from state only.
REQ-020: IDLE -> FETCH when start=1; otherwise remain in IDLE.
REQ-021: FETCH SHALL hold imem_req=1 until imem_ready=1; on that cycle IR <= imem_rdata and state -> DECODE; fetch wait is unbounded.
REQ-022: DECODE SHALL last exactly 1 cycle; opcode = IR[19:15]; opcode 5'b11111 -> HALT, otherwise -> EXEC.
REQ-023: EXEC SHALL assert alu_en for exactly 1 cycle.
REQ-024: EXEC with opcode 01001 (jump): pc <= jump_address, -> FETCH.
REQ-025: EXEC with opcode 01010: if alu_zero=1, pc <= pc+1+branch_offset; else pc <= pc+1; -> FETCH.
REQ-026: EXEC with opcode 01011: same as REQ-025 with the taken condition alu_zero=0.
REQ-027: Branch arithmetic SHALL be 8-bit two's-complement and wrap modulo 256; pc+1 also wraps (255 -> 0).
REQ-028: EXEC with opcode 00111 (lw) or 01000 (sw) -> MEM; all other opcodes -> WB.
REQ-029: MEM SHALL hold dmem_req=1, with dmem_we=1 only for sw, until dmem_ready=1.
REQ-030: On dmem_ready in MEM: lw -> WB; sw -> pc <= pc+1, -> FETCH.
REQ-031: WB SHALL assert reg_we for exactly 1 cycle, set pc <= pc+1, -> FETCH.
REQ-032: reg_we SHALL never be asserted for jump, branch, sw or halt.
REQ-033: HALT is terminal: halted=1, pc frozen, no requests issued; only reset exits.
REQ-034: imem_req and dmem_req SHALL never be high in the same cycle.
REQ-035: Ready inputs arriving outside FETCH/MEM SHALL be ignored.

Reset
REQ-036: Reset SHALL immediately force state=IDLE, pc=0, IR=0, and all request and strobe outputs and halted to 0.
REQ-037: Reset asserted mid-transaction SHALL abandon the access; the first cycle after release is in IDLE.

Configuration
REQ-038: With macro CPU_SEQUENCER_RETIRE_CNT_EN defined, the block SHALL add output retire_cnt[15:0], reset to 0, incremented once per completed instruction (entry to FETCH from EXEC, MEM or WB) and wrapping at 65535 -> 0.
REQ-039: Without the macro, the retire_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-040: reset, start=1, imem_ready=1 immediately, IR opcode 00000 -> states FETCH, DECODE, EXEC, WB, FETCH; reg_we pulses once; pc 0 -> 1.
REQ-041: jump with jump_address=8'h3C -> pc=8'h3C at the next FETCH; reg_we stays 0.
REQ-042: opcode 01010 at pc=8'h05, branch_offset=-3, alu_zero=1 -> pc=8'h03; the same case with alu_zero=0 -> pc=8'h06.
REQ-043: sw with dmem_ready delayed 4 cycles -> dmem_req=1 and dmem_we=1 for 5 cycles, no reg_we, pc+1; lw -> dmem_we=0, then a WB reg_we pulse.
REQ-044: opcode 11111 -> HALT, halted=1, no further imem_req for 20 cycles; reset during a MEM wait -> IDLE, pc=0.
REQ-045: with CPU_SEQUENCER_RETIRE_CNT_EN defined, 3 instructions retired -> retire_cnt=3; pc=8'hFF plus a not-taken branch -> pc wraps to 0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch / decode / execute / memory / write-back control.
// Optional retire counter port enabled by defining CPU_SEQUENCER_RETIRE_CNT_EN.
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ready,
    input  logic [19:0] imem_rdata,
    output logic [19:0] instruction,
    input  logic [7:0]  jump_address,
    input  logic [7:0]  branch_offset,
    input  logic        alu_zero,
    output logic        alu_en,
    output logic        reg_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic [7:0]  pc,
    output logic [2:0]  state,
    output logic        halted
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
    ,
    output logic [15:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [4:0] OP_LW   = 5'b00111;
    localparam logic [4:0] OP_SW   = 5'b01000;
    localparam logic [4:0] OP_JMP  = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_BNE  = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [19:0] ir_q, ir_d;
    logic [4:0]  opcode;
    logic [7:0]  pc_inc;

    assign opcode = ir_q[19:15];
    assign pc_inc = pc_q + 8'd1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= 8'd0;
            ir_q    <= 20'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                unique case (opcode)
                    OP_JMP: begin
                        pc_d    = jump_address;
                        state_d = S_FETCH;
                    end
                    OP_BEQ, OP_BNE: begin
                        // Taken condition flips between the two branch flavours.
                        if (alu_zero == (opcode == OP_BEQ)) pc_d = pc_inc + branch_offset;
                        else                                pc_d = pc_inc;
                        state_d = S_FETCH;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode from the registered state (and IR) only, so reset clears them at once.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instruction = ir_q;
    assign alu_en      = (state_q == S_EXEC);
    assign reg_we      = (state_q == S_WB);
    assign dmem_req    = (state_q == S_MEM);
    assign dmem_we     = (state_q == S_MEM) && (opcode == OP_SW);
    assign pc          = pc_q;
    assign state       = state_q;
    assign halted      = (state_q == S_HALT);

`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
    logic [15:0] retire_q;
    logic        retire_evt;

    assign retire_evt = (state_d == S_FETCH) &&
                        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           retire_q <= 16'd0;
        else if (retire_evt) retire_q <= retire_q + 16'd1;
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed cases then randomized instruction stream,
// checked against a per-instruction state-sequence model. Honors CPU_SEQUENCER_RETIRE_CNT_EN.
module tb_cpu_sequencer;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3,
                   ST_MEM = 4, ST_WB = 5, ST_HALT = 6;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        imem_req, imem_ready;
    logic [7:0]  imem_addr;
    logic [19:0] imem_rdata, instruction;
    logic [7:0]  jump_address, branch_offset;
    logic        alu_zero, alu_en, reg_we, dmem_req, dmem_we, dmem_ready;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        halted;
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  model_pc    = 8'd0;
    int          model_retire = 0;

    cpu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .jump_address (jump_address),
        .branch_offset(branch_offset),
        .alu_zero     (alu_zero),
        .alu_en       (alu_en),
        .reg_we       (reg_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .pc           (pc),
        .state        (state),
        .halted       (halted)
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
        ,
        .retire_cnt   (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_retire();
`ifdef CPU_SEQUENCER_RETIRE_CNT_EN
        check("retire_cnt", 32'(retire_cnt), 32'(16'(model_retire)));
`endif
    endtask

    // Builds the expected per-cycle state list for one instruction and walks the DUT through it.
    task automatic do_instr(input logic [19:0] word, input logic [7:0] jaddr, input logic [7:0] boff,
                            input logic azero, input int fwait, input int mwait);
        logic [4:0] op;
        logic [7:0] next_pc;
        int         q[$];
        int         e;
        bit         last, is_halt, writes_back;
        op      = word[19:15];
        is_halt = (op == 5'b11111);
        repeat (fwait + 1) q.push_back(ST_FETCH);
        q.push_back(ST_DECODE);
        if (is_halt) begin
            repeat (20) q.push_back(ST_HALT);
        end else begin
            q.push_back(ST_EXEC);
            if (op == 5'b00111 || op == 5'b01000) repeat (mwait + 1) q.push_back(ST_MEM);
            writes_back = !(op inside {5'b01000, 5'b01001, 5'b01010, 5'b01011});
            if (writes_back) q.push_back(ST_WB);
        end

        if (is_halt)                                   next_pc = model_pc;
        else if (op == 5'b01001)                       next_pc = jaddr;
        else if (op == 5'b01010 && azero)              next_pc = model_pc + 8'd1 + boff;
        else if (op == 5'b01011 && !azero)             next_pc = model_pc + 8'd1 + boff;
        else                                           next_pc = model_pc + 8'd1;

        imem_rdata    = word;
        jump_address  = jaddr;
        branch_offset = boff;
        for (int k = 0; k < q.size(); k++) begin
            e = q[k];
            if (k == q.size() - 1) last = 1'b1;
            else                   last = (q[k+1] != e);
            imem_ready = (e == ST_FETCH) ? last : 1'($urandom_range(0, 1));
            dmem_ready = (e == ST_MEM)   ? last : 1'($urandom_range(0, 1));
            alu_zero   = (e == ST_EXEC)  ? azero : 1'($urandom_range(0, 1));
            check("state",    32'(state),    32'(e));
            check("imem_req", 32'(imem_req), 32'(e == ST_FETCH));
            check("dmem_req", 32'(dmem_req), 32'(e == ST_MEM));
            check("dmem_we",  32'(dmem_we),  32'(e == ST_MEM && op == 5'b01000));
            check("alu_en",   32'(alu_en),   32'(e == ST_EXEC));
            check("reg_we",   32'(reg_we),   32'(e == ST_WB));
            check("halted",   32'(halted),   32'(e == ST_HALT));
            check("pc",       32'(pc),       32'(model_pc));
            check("imem_addr",32'(imem_addr),32'(model_pc));
            if (e == ST_DECODE) check("instruction", 32'(instruction), 32'(word));
            step();
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        model_pc   = next_pc;
        if (!is_halt) begin
            model_retire++;
            check("pc_after", 32'(pc), 32'(model_pc));
            check("state_after", 32'(state), 32'(ST_FETCH));
        end
        check_retire();
    endtask

    task automatic check_idle_reset_values();
        check("rst_state",  32'(state),       32'(ST_IDLE));
        check("rst_pc",     32'(pc),          32'd0);
        check("rst_ir",     32'(instruction), 32'd0);
        check("rst_imem",   32'(imem_req),    32'd0);
        check("rst_dmem",   32'(dmem_req),    32'd0);
        check("rst_dwe",    32'(dmem_we),     32'd0);
        check("rst_alu",    32'(alu_en),      32'd0);
        check("rst_regwe",  32'(reg_we),      32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check_retire();
    endtask

    task automatic begin_run();
        start = 1'b0;
        repeat (2) begin
            imem_ready = 1'($urandom_range(0, 1));
            dmem_ready = 1'($urandom_range(0, 1));
            step();
            check("idle_hold", 32'(state), 32'(ST_IDLE));
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        start      = 1'b1;
        step();
        check("start_fetch", 32'(state), 32'(ST_FETCH));
    endtask

    initial begin
        logic [4:0]  op;
        logic [19:0] word;
        reset = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_rdata = '0; jump_address = '0; branch_offset = '0; alu_zero = 1'b0;
        #2;
        check_idle_reset_values();
        step();
        step();
        reset = 1'b0;
        check_idle_reset_values();
        begin_run();

        // Directed: plain ALU op, jump, both branch outcomes, sw/lw with waits, pc wrap.
        do_instr({5'b00000, 15'h1234}, 8'h00, 8'h00, 1'b0, 0, 0);
        do_instr({5'b01001, 15'h0000}, 8'h3C, 8'h00, 1'b0, 1, 0);
        do_instr({5'b01001, 15'h0000}, 8'h05, 8'h00, 1'b0, 0, 0);
        do_instr({5'b01010, 15'h0000}, 8'h00, 8'hFD, 1'b1, 0, 0);
        check("beq_taken_pc", 32'(pc), 32'h03);
        do_instr({5'b01001, 15'h0000}, 8'h05, 8'h00, 1'b0, 0, 0);
        do_instr({5'b01010, 15'h0000}, 8'h00, 8'hFD, 1'b0, 0, 0);
        check("beq_not_taken_pc", 32'(pc), 32'h06);
        do_instr({5'b01011, 15'h0000}, 8'h00, 8'h10, 1'b0, 2, 0);
        do_instr({5'b01000, 15'h0042}, 8'h00, 8'h00, 1'b0, 0, 4);
        do_instr({5'b00111, 15'h0042}, 8'h00, 8'h00, 1'b0, 0, 2);
        do_instr({5'b01001, 15'h0000}, 8'hFF, 8'h00, 1'b0, 0, 0);
        do_instr({5'b01010, 15'h0000}, 8'h00, 8'h20, 1'b0, 0, 0);
        check("pc_wrap", 32'(pc), 32'h00);
        do_instr({5'b01001, 15'h0000}, 8'hFF, 8'h00, 1'b0, 0, 0);
        do_instr({5'b00000, 15'h0000}, 8'h00, 8'h00, 1'b0, 0, 0);
        check("wb_wrap", 32'(pc), 32'h00);

        // Randomized instruction stream, biased towards control-flow and memory opcodes.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 6))
                0:       op = 5'b00000;
                1:       op = 5'b00111;
                2:       op = 5'b01000;
                3:       op = 5'b01001;
                4:       op = 5'b01010;
                5:       op = 5'b01011;
                default: op = 5'($urandom_range(0, 30));
            endcase
            word = {op, 15'($urandom)};
            do_instr(word, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Halt is terminal: twenty cycles with no fetch and a frozen pc.
        do_instr({5'b11111, 15'h0000}, 8'h00, 8'h00, 1'b0, 1, 0);

        // Reset in the middle of a data-memory wait.
        reset = 1'b1;
        #2;
        model_pc = 8'd0;
        model_retire = 0;
        check_idle_reset_values();
        step();
        reset = 1'b0;
        begin_run();
        do_instr({5'b00000, 15'h0000}, 8'h00, 8'h00, 1'b0, 0, 0);
        imem_rdata = {5'b00111, 15'h0000};
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        check("mem_wait_state", 32'(state), 32'(ST_MEM));
        step();
        #2;
        reset = 1'b1;
        #1;
        model_pc = 8'd0;
        model_retire = 0;
        check_idle_reset_values();
        step();
        reset = 1'b0;
        start = 1'b0;
        step();
        check("post_reset_idle", 32'(state), 32'(ST_IDLE));
        check("post_reset_pc",   32'(pc),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
